// File: rtl/softmax_result_collector.sv
// Collects one descending-index softmax burst, restores ascending order in a local
// buffer, tracks the argmax, and replays the frame on a valid/ready stream.
module softmax_result_collector #(
  parameter int BITWIDTH = 32,
  parameter int INPUTMAX = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [INPUTMAX:0]   N,
  input  logic [BITWIDTH-1:0] Datain,
  input  logic                Datain_vld,
  output logic [BITWIDTH-1:0] Dataout,
  output logic                Dataout_vld,
  input  logic                Dataout_rdy,
  output logic                Dataout_last,
  output logic [INPUTMAX-1:0] Argmax,
  output logic                Argmax_vld,
  output logic                Busy,
  output logic                Overrun
);

  // state   | meaning
  // IDLE    | waiting for the first beat of a frame
  // CAPTURE | storing beats, write index counting down to 0
  // DRAIN   | replaying ascending order, argmax valid
  localparam int DEPTH = 2 ** INPUTMAX;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;

  logic [1:0]          state;
  logic [BITWIDTH-1:0] buffer [DEPTH];
  logic [INPUTMAX-1:0] neff;
  logic [INPUTMAX-1:0] wr;
  logic [INPUTMAX-1:0] rd;
  logic [INPUTMAX-1:0] argmax_idx;
  logic [BITWIDTH-2:0] max_mag;
  logic [INPUTMAX-1:0] n_clamp;
  logic                overrun_q;
  logic                handshake;
  logic                new_max;

  // Depth-1 is all ones in the low bits, so any frame length that sets the top bit clamps
  assign n_clamp   = N[INPUTMAX] ? '1 : N[INPUTMAX-1:0];
  assign handshake = (state == S_DRAIN) && Dataout_rdy;
  // >= lets later (lower-index) beats win ties
  assign new_max   = Datain[BITWIDTH-2:0] >= max_mag;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      neff       <= '0;
      wr         <= '0;
      rd         <= '0;
      argmax_idx <= '0;
      max_mag    <= '0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Datain_vld) begin
            buffer[n_clamp] <= Datain;
            neff            <= n_clamp;
            max_mag         <= Datain[BITWIDTH-2:0];
            argmax_idx      <= n_clamp;
            rd              <= '0;
            if (n_clamp == '0) begin
              state <= S_DRAIN;
            end else begin
              state <= S_CAPTURE;
              wr    <= n_clamp - 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (Datain_vld) begin
            buffer[wr] <= Datain;
            if (new_max) begin
              max_mag    <= Datain[BITWIDTH-2:0];
              argmax_idx <= wr;
            end
            if (wr == '0) state <= S_DRAIN;
            else          wr    <= wr - 1'b1;
          end
        end
        S_DRAIN: begin
          if (Datain_vld) overrun_q <= 1'b1;
          if (handshake) begin
            if (rd == neff) begin
              state <= S_IDLE;
              rd    <= '0;
            end else begin
              rd <= rd + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Dataout      = (state == S_DRAIN) ? buffer[rd] : '0;
  assign Dataout_vld  = (state == S_DRAIN);
  assign Dataout_last = (state == S_DRAIN) && (rd == neff);
  assign Argmax       = argmax_idx;
  assign Argmax_vld   = (state == S_DRAIN);
  assign Busy         = (state != S_IDLE);
  assign Overrun      = overrun_q;

endmodule

// File: doc/softmax_result_collector.md
Name: softmax_result_collector

Overview:
- Receiving end of the softmax accelerator's output stream.
- Captures one Dataout/Dataout_vld burst, which the accelerator emits highest index first. Restores ascending index order in a local buffer and tracks the index of the largest probability.
- Replays the frame downstream on a valid/ready interface with a last flag.
- Sits between the softmax core and the classification/readout logic.

Parameters:
- BITWIDTH, 32, data word width (IEEE-754 single for the softmax path).
- INPUTMAX, 2, log2 of buffer depth; depth = 2**INPUTMAX entries.

Ports:
- Clock  input  1  single clock, all logic on rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- N  input  [INPUTMAX:0]  frame length minus one; sampled on the first captured beat.
- Datain  input  [BITWIDTH-1:0]  softmax output word.
- Datain_vld  input  1  Datain valid; one word per high cycle, gaps allowed.
- Dataout  output  [BITWIDTH-1:0]  replayed word, ascending index.
- Dataout_vld  output  1  Dataout valid.
- Dataout_rdy  input  1  downstream accepts when high together with Dataout_vld.
- Dataout_last  output  1  high with the final word (index N) of the frame.
- Argmax  output  [INPUTMAX-1:0]  index of the largest word in the frame.
- Argmax_vld  output  1  Argmax valid; high for the whole DRAIN state.
- Busy  output  1  high in CAPTURE or DRAIN.
- Overrun  output  1  sticky; a Datain_vld beat arrived during DRAIN and was dropped. Cleared only by reset.

Behaviour:
- Reset (async, Reset==0), all outputs low/zero:
  - Dataout, Dataout_vld, Dataout_last, Argmax, Argmax_vld, Busy, Overrun all 0.
  - Buffer contents cleared to 0; state IDLE.
- Reset mid-frame aborts immediately; no partial drain follows.
- States: IDLE, CAPTURE, DRAIN.
- N clamp: effective length Neff = min(N, 2**INPUTMAX-1), latched on the first beat. Later changes to N are ignored until IDLE.
- Beat ordering: beat k (k=0 first) is written to Buffer[Neff-k]; the wr index counts down from Neff to 0.
- IDLE:
  - On Datain_vld=1: latch Neff, write Buffer[Neff], init max tracker with this word/index.
  - If Neff==0, go to DRAIN; else go to CAPTURE with wr index = Neff-1.
- CAPTURE:
  - Each Datain_vld=1 cycle: write Buffer[wr], compare with tracker, decrement wr.
  - The beat written at wr==0 moves to DRAIN next cycle.
  - Datain_vld=0 cycles hold state; there is no timeout.
- Max compare:
  - Unsigned compare of bits [BITWIDTH-2:0]; sign bit ignored, since softmax outputs are non-negative.
  - New beat replaces the tracked max when its magnitude >= current max. Because indices arrive descending, ties resolve to the lowest index.
- DRAIN:
  - Dataout_vld=1 starting the cycle after the final capture beat; rd index starts at 0.
  - Dataout = Buffer[rd]; Dataout_last = (rd==Neff).
  - Argmax_vld=1, Argmax held stable.
  - On Dataout_vld && Dataout_rdy: rd increments. On the last handshake, go to IDLE next cycle, dropping Dataout_vld, Dataout_last and Argmax_vld.
  - Dataout, Dataout_last and Dataout_vld stay stable while Dataout_rdy=0 (no retraction).
- Datain_vld=1 during DRAIN: word dropped, Overrun set next cycle, buffer untouched.
- Last drain handshake coinciding with Datain_vld=1: the word is dropped (Overrun set). The new frame starts only on a beat seen in IDLE.
- Busy = (state != IDLE), registered with the state.
- Capture throughput: one word per clock. Drain throughput: one word per clock with Dataout_rdy tied high.
- Latency from final capture beat to first Dataout_vld: 1 cycle.

Test Plan:
- Basic four-word frame:
  - Stimulus: N=3, beats 0x3E000000, 0x3E800000, 0x3F000000, 0x3D800000 (indices 3,2,1,0) back-to-back; Dataout_rdy=1.
  - Response: Dataout sequence 0x3D800000, 0x3F000000, 0x3E800000, 0x3E000000; Dataout_last on the 4th word; Argmax=1 with Argmax_vld high for 4 cycles.
- Tie handling:
  - Stimulus: N=2, all three beats 0x3EAAAAAB.
  - Response: Argmax=0.
- Single-word frame and backpressure:
  - Stimulus: N=0, beat 0x3F800000; Dataout_rdy low for 5 cycles, then high.
  - Response: Dataout_vld and Dataout_last high and stable for 6 cycles; Argmax=0; Busy drops the cycle after the handshake.
- Gapped input and clamp:
  - Stimulus: N=7 (clamped to 3); beats with 2-cycle Datain_vld gaps.
  - Response: exactly 4 beats captured; ordering as in the basic four-word frame.
- Overrun:
  - Stimulus: in DRAIN with Dataout_rdy=0, pulse Datain_vld with 0x12345678.
  - Response: Overrun=1 and sticky; replayed data unchanged.
  - After the drain completes, a fresh frame captures normally.
- Async reset:
  - Stimulus: assert Reset=0 mid-CAPTURE (two of four beats received), asynchronous to Clock.
  - Response: all outputs 0 immediately; after release, the next frame captures from scratch with correct order.
